// File: rtl/cap_dmem_responder.sv
// cap_dmem_responder: data-memory responder with fixed wait states and capability-width beat bursts
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   comp_en_i           1 = compressed 64-bit capabilities, 0 = uncompressed 129-bit; sampled at accept
//   req_valid_i/ready_o request handshake; ready only while idle
//   req_we_i, req_cap_i store/load select, capability-width/word access select
//   req_addr_i          byte address, word index taken from [ADDR_W+1:2]
//   req_wdata_i         store data
//   rsp_valid_o/last_o  one beat per cycle, last marks the final beat
//   rsp_rdata_o         load beat data, zero on store beats
//   busy_o, stall_cnt_o non-idle flag and saturating count of busy cycles
module cap_dmem_responder #(
    parameter int ADDR_W    = 12,
    parameter int WAIT_BASE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        comp_en_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic        req_cap_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_last_o,
    output logic        busy_o,
    output logic [31:0] stall_cnt_o
);
    localparam int WW = (WAIT_BASE > 1) ? $clog2(WAIT_BASE) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;
    state_t              state_q;
    logic                we_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic [2:0]          n_q;
    logic [2:0]          k_q;
    logic [WW-1:0]       wcnt_q;
    logic                rsp_valid_q;
    logic                rsp_last_q;
    logic [31:0]         stall_q;
    logic [31:0]         rd_q;
    logic [31:0]         mem [2**ADDR_W];
    logic [ADDR_W-1:0]   req_idx;
    logic [ADDR_W-1:0]   rd_idx_d;
    logic [2:0]          req_n;
    logic                mem_we;
    logic                unused_addr_bits;
    assign req_idx          = req_addr_i[ADDR_W+1:2];
    assign unused_addr_bits = ^{req_addr_i[31:ADDR_W+2], req_addr_i[1:0]};
    assign req_n            = !req_cap_i ? 3'd1 : comp_en_i ? 3'd2 : 3'd5;
    // The array read is registered, so the address presented each cycle is the
    // one for the beat that appears in the following cycle.
    always_comb begin
        rd_idx_d = state_q == IDLE ? req_idx :
                   state_q == WAIT ? idx_q   :
                   idx_q + ADDR_W'(k_q) + ADDR_W'(1);
    end
    assign mem_we = state_q == BEAT && k_q == 3'd0 && we_q;
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= wdata_q;
        rd_q <= mem[rd_idx_d];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            n_q         <= 3'd1;
            k_q         <= 3'd0;
            wcnt_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            stall_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            if (state_q != IDLE && stall_q != '1) stall_q <= stall_q + 32'd1;
            case (state_q)
                IDLE: if (req_valid_i) begin
                    we_q    <= req_we_i;
                    idx_q   <= req_idx;
                    wdata_q <= req_wdata_i;
                    n_q     <= req_n;
                    k_q     <= 3'd0;
                    wcnt_q  <= '0;
                    if (WAIT_BASE == 0) begin
                        state_q     <= BEAT;
                        rsp_valid_q <= 1'b1;
                        rsp_last_q  <= req_n == 3'd1;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: if (wcnt_q == WW'(WAIT_BASE - 1)) begin
                    state_q     <= BEAT;
                    rsp_valid_q <= 1'b1;
                    rsp_last_q  <= n_q == 3'd1;
                end else begin
                    wcnt_q <= wcnt_q + WW'(1);
                end
                BEAT: if (rsp_last_q) begin
                    state_q <= IDLE;
                end else begin
                    k_q         <= k_q + 3'd1;
                    rsp_valid_q <= 1'b1;
                    rsp_last_q  <= k_q + 3'd2 == n_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign req_ready_o = state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_last_o  = rsp_last_q;
    assign rsp_rdata_o = (rsp_valid_q && !we_q) ? rd_q : '0;
    assign stall_cnt_o = stall_q;
endmodule

// File: tb/tb_cap_dmem_responder.sv
// tb_cap_dmem_responder: directed scoreboard bench for cap_dmem_responder
module tb_cap_dmem_responder;
    localparam int W  = 2;
    localparam int AW = 12;
    localparam int D  = 1 << AW;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        comp_en = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        req_cap = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_last_o;
    logic        busy_o;
    logic [31:0] stall_cnt_o;
    cap_dmem_responder #(.ADDR_W(AW), .WAIT_BASE(W)) dut (
        .clk(clk), .rst_n(rst_n), .comp_en_i(comp_en), .req_valid_i(req_valid),
        .req_ready_o(req_ready_o), .req_we_i(req_we), .req_cap_i(req_cap),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_last_o(rsp_last_o), .busy_o(busy_o),
        .stall_cnt_o(stall_cnt_o)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] d;
        logic        l;
        int          k;
    } beat_t;
    beat_t       sb[$];
    logic [31:0] mdl [int];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc = 0;
    int exp_stall = 0;
    int a1 = 0;
    bit post_last = 1'b0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask
    task automatic push_load(input logic [31:0] addr, input int n);
        int idx;
        idx = int'((addr >> 2) & (D - 1));
        for (int k = 0; k < n; k++) sb.push_back('{mdl[(idx + k) % D], k == n - 1, k});
    endtask
    task automatic send(input logic we, input logic cap, input logic ce,
                        input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = !cap ? 1 : ce ? 2 : 5;
        if (we) begin
            for (int k = 0; k < n; k++) sb.push_back('{32'h0, k == n - 1, k});
            mdl[int'((addr >> 2) & (D - 1))] = wd;
        end else begin
            push_load(addr, n);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = we; req_cap = cap; comp_en = ce;
        req_addr = addr; req_wdata = wd;
        for (int t = 0; t < 100 && !req_ready_o; t++) begin
            @(posedge clk);
            #1;
        end
        chk("ready_wait", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_stall += W + n;
    endtask
    task automatic wait_idle();
        for (int t = 0; t < 200 && (sb.size() != 0 || !req_ready_o); t++) @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        chk("stall_cnt", stall_cnt_o, 32'(exp_stall));
    endtask
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            post_last <= 1'b0;
        end else begin
            if (post_last) begin
                chk("ready_after_last", 32'(req_ready_o), 32'd1);
                chk("busy_after_last", 32'(busy_o), 32'd0);
                post_last <= 1'b0;
            end
            if (req_valid && req_ready_o) acc <= cyc + 1;
            if (rsp_valid_o) begin
                chk("beat_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("beat_data", rsp_rdata_o, e.d);
                    chk("beat_last", 32'(rsp_last_o), 32'(e.l));
                    chk("beat_cycle", 32'(cyc), 32'(acc + W + e.k));
                    chk("beat_busy", 32'(busy_o), 32'd1);
                    if (e.l) post_last <= 1'b1;
                end
            end
        end
    end
    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_last", 32'(rsp_last_o), 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_stall", stall_cnt_o, 32'd0);
        rst_n = 1'b1;
        send(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
        wait_idle();
        send(1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b0, 1'b0, 32'h20 + 32'(4 * i), 32'h11 * 32'(i + 1));
            wait_idle();
        end
        send(1'b0, 1'b1, 1'b1, 32'h20, 32'h0);
        wait_idle();
        send(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
        wait_idle();
        send(1'b1, 1'b0, 1'b0, 32'h3FFC, 32'hA5A50FFF);
        send(1'b1, 1'b0, 1'b0, 32'h0, 32'h5A5A0000);
        send(1'b0, 1'b1, 1'b1, 32'h0001_3FFF, 32'h0);
        wait_idle();
        send(1'b1, 1'b0, 1'b0, 32'h104, 32'h66);
        send(1'b1, 1'b1, 1'b0, 32'h100, 32'h77);
        send(1'b0, 1'b1, 1'b1, 32'h100, 32'h0);
        wait_idle();
        // held request across a 5-beat load, comp_en toggling in flight
        push_load(32'h20, 5);
        push_load(32'h28, 2);
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = 1'b0; req_cap = 1'b1; comp_en = 1'b0; req_addr = 32'h20;
        chk("t5_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        a1 = acc;
        comp_en = 1'b1;
        req_addr = 32'h28;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            comp_en = ~comp_en;
            chk("held_not_accepted", 32'(req_ready_o), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("idle_at_cycle8", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("accept_spacing", 32'(acc - a1), 32'd8);
        exp_stall += (W + 5) + (W + 2);
        wait_idle();
        // reset during beat 2 of a 5-beat load
        sb.push_back('{mdl[8], 1'b0, 0});
        sb.push_back('{mdl[9], 1'b0, 1});
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = 1'b0; req_cap = 1'b1; comp_en = 1'b0; req_addr = 32'h20;
        chk("t6_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_stall = 0;
        chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_last", 32'(rsp_last_o), 32'd0);
        chk("mid_rst_rdata", rsp_rdata_o, 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
        chk("mid_rst_stall", stall_cnt_o, 32'd0);
        @(negedge clk);
        chk("mid_rst_drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cap_dmem_responder.md
# cap_dmem_responder

Data-memory responder for the capability-width CPI study: the memory end of the core's load/store port. It accepts one request at a time, inserts a fixed wait-state latency, then returns a burst of 32-bit beats whose count depends on access type and capability format (compressed 64-bit vs. uncompressed 129-bit). It also counts busy cycles, so sweeps can attribute CPI changes to capability width.

## Interface
Parameters:
- ADDR_W, 12, word-address bits; memory depth is 2^ADDR_W 32-bit words
- WAIT_BASE, 2, wait cycles between accept and the first beat (0 legal)

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- comp_en  in  1  1 = compressed capabilities (64-bit), 0 = uncompressed (129-bit); sampled at accept
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_cap  in  1  1 = capability-width access, 0 = plain word access
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  store data
- rsp_valid  out  1  one beat delivered this cycle
- rsp_rdata  out  32  load beat data; 0 for stores
- rsp_last  out  1  final beat of the transfer (qualified by rsp_valid)
- busy  out  1  state != IDLE
- stall_cnt  out  32  saturating count of busy cycles since reset

## Operation
- States: IDLE, WAIT, BEAT.
- IDLE: req_ready=1. req_valid=1 accepts on the rising edge. Latch we, addr index = req_addr[ADDR_W+1:2], wdata, and beat count N:
  - N = 1 if req_cap=0
  - N = 2 if req_cap=1 and comp_en=1
  - N = 5 if req_cap=1 and comp_en=0 (4 data words + tag word)
- Next state is WAIT if WAIT_BASE>0, else BEAT.
- WAIT: count WAIT_BASE cycles, then go to BEAT.
- BEAT k (k=0..N-1): rsp_valid=1. rsp_last=1 when k=N-1.
  - Load: rsp_rdata = mem[(index+k) mod 2^ADDR_W].
  - Store: beat 0 writes the latched wdata to mem[index]; later beats are timing-only with no array write. rsp_rdata=0 on every store beat.
- After beat N-1, return to IDLE.
- req_valid while not IDLE is ignored. The requester holds its request; it is accepted at the first IDLE cycle.
- comp_en or request inputs changing after accept do not affect the transfer in flight.
- stall_cnt increments every cycle busy=1 and saturates at 0xFFFFFFFF.
- Memory array is not reset. Contents survive rst_n and are undefined at power-up.

## Timing
- Accept edge = cycle 0. WAIT occupies cycles 1..WAIT_BASE. Beats occupy cycles WAIT_BASE+1 .. WAIT_BASE+N. IDLE (req_ready=1) at cycle WAIT_BASE+N+1.
- Load data is registered (synchronous array read) and valid in the same cycle as rsp_valid.
- Busy cycles per transfer = WAIT_BASE+N. Back-to-back accepts are spaced by WAIT_BASE+N+1 cycles.
- Reset values:
  - state IDLE, req_ready=1, rsp_valid=0, rsp_last=0, rsp_rdata=0, busy=0, stall_cnt=0.
- Reset mid-transfer: on rst_n falling, outputs take their reset values immediately with no clock edge. No rsp_last is issued for the aborted transfer. A store whose beat 0 already occurred stays written.

## Test plan
1. WAIT_BASE=2, store 0xDEADBEEF to 0x10 at cycle 0 -> rsp_valid=rsp_last=1 at cycle 3, req_ready=1 at cycle 4. Plain load from 0x10 then returns 0xDEADBEEF on its single beat; stall_cnt=6 after both.
2. Preload words 0x20,0x24 with 0x11,0x22; cap load at 0x20 with comp_en=1 -> beats at cycles 3,4 with data 0x11,0x22; rsp_last only at cycle 4; stall_cnt +4.
3. Same load with comp_en=0 -> 5 beats at cycles 3..7; rsp_last at cycle 7; stall_cnt +7.
4. Wrap: with words 0 and 2^ADDR_W-1 preloaded, cap load (comp_en=1) at byte address 4*(2^ADDR_W-1) -> beat 0 = last word, beat 1 = word 0.
5. Hold req_valid across a 5-beat transfer and toggle comp_en during it -> still exactly 5 beats. The second request is accepted at cycle 8, the first IDLE cycle, and is never accepted earlier.
6. Assert rst_n low during beat 2 of a 5-beat load -> rsp_valid=0, busy=0, req_ready=1, stall_cnt=0 immediately. No rsp_last is seen. A subsequent load returns the pre-reset memory contents.
